// File: rtl/bitfield_pkg.sv
// Shared definitions for the bitfield merge block.
//   clog2    : ceiling log2 used to size length and address fields
//   lowmask  : n low bits set; n == 0 means all bits set
//   MODE_*   : stage-1 operation select encodings
package bitfield_pkg;

  // Widest datapath the lowmask helper supports; callers cast down to W.
  localparam int unsigned MaxW = 64;

  localparam logic MODE_INSERT  = 1'b0;
  localparam logic MODE_EXTRACT = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic logic [MaxW-1:0] lowmask(input int unsigned n);
    if (n == 0 || n >= MaxW) begin
      return '1;
    end
    return (MaxW'(1) << n) - MaxW'(1);
  endfunction

endpackage

// File: rtl/bitfield_merge_if.sv
// Bus bundle between a bitfield_merge and the logic that drives it.
//   master : drives stall, stage-1 controls (field_in, len, mode, rd_addr) and
//            stage-2 controls (pos, wr_en, wr_addr); observes the outputs
//   slave  : the bitfield_merge side; drives data_out, field_out, out_valid
interface bitfield_merge_if
  import bitfield_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned NLATCH = 2
);

  localparam int unsigned LW = clog2(W);
  localparam int unsigned AW = clog2(NLATCH);

  logic                  stall;
  logic [W-1:0]          field_in;
  logic [LW-1:0]         len;
  logic                  mode;
  logic [AW-1:0]         rd_addr;
  logic [LW-1:0]         pos;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [NLATCH*W-1:0]   data_out;
  logic [W-1:0]          field_out;
  logic                  out_valid;

  modport master (
    output stall, field_in, len, mode, rd_addr, pos, wr_en, wr_addr,
    input  data_out, field_out, out_valid
  );

  modport slave (
    input  stall, field_in, len, mode, rd_addr, pos, wr_en, wr_addr,
    output data_out, field_out, out_valid
  );

endinterface

// File: rtl/field_mask_gen.sv
// Field length to low-bit mask.
//   len_i  : field length; 0 selects the full width
//   mask_o : bits len_i-1..0 set (all ones when len_i == 0)
module field_mask_gen
  import bitfield_pkg::*;
#(
  parameter int unsigned W    = 8,
  localparam int unsigned LW  = clog2(W)
) (
  input  logic [LW-1:0] len_i,
  output logic [W-1:0]  mask_o
);

  assign mask_o = W'(lowmask(32'(len_i)));

endmodule

// File: rtl/bitfield_merge.sv
// Two-stage bitfield insert/extract over a small array of W-bit latches.
//   clk, rst  : clock and synchronous active-high reset
//   bus       : slave side of bitfield_merge_if
//     stage 1 : field_in/len/mode/rd_addr are registered (field masked,
//               inverse mask, latch read with write forwarding)
//     stage 2 : pos/wr_en/wr_addr act on the stage-1 registers; insert writes
//               a latch, extract loads field_out and pulses out_valid
//     data_out: all latches, latch 0 in the MSBs
module bitfield_merge
  import bitfield_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned NLATCH = 2,
  localparam int unsigned LW    = clog2(W),
  localparam int unsigned AW    = clog2(NLATCH)
) (
  input logic            clk,
  input logic            rst,
  bitfield_merge_if.slave bus
);

  logic [W-1:0]  latch_q [NLATCH];
  logic [W-1:0]  latch_d [NLATCH];
  logic [W-1:0]  merge_in_q, merge_in_d;
  logic [W-1:0]  field_reg_q, field_reg_d;
  logic [W-1:0]  mask_reg_q, mask_reg_d;
  logic [LW-1:0] len_reg_q, len_reg_d;
  logic          mode_reg_q, mode_reg_d;
  logic [W-1:0]  field_out_q, field_out_d;
  logic          out_valid_q, out_valid_d;

  logic [W-1:0]  len_mask;
  logic [W-1:0]  ext_mask;
  logic [W-1:0]  field_shift;
  logic [W-1:0]  mask_rot;
  logic [W-1:0]  insert_res;
  logic [W-1:0]  rd_data;
  logic          wr_fire;
  logic          ext_fire;

  field_mask_gen #(
    .W (W)
  ) u_len_mask (
    .len_i  (bus.len),
    .mask_o (len_mask)
  );

  field_mask_gen #(
    .W (W)
  ) u_ext_mask (
    .len_i  (len_reg_q),
    .mask_o (ext_mask)
  );

  // The field truncates at the top while the keep-mask rotates, so a field
  // that wraps past bit W-1 clears the wrapped low bits of the destination.
  always_comb begin
    field_shift = field_reg_q << bus.pos;
    mask_rot    = (mask_reg_q << bus.pos) | (mask_reg_q >> (W - 32'(bus.pos)));
    insert_res  = field_shift | (merge_in_q & mask_rot);
  end

  always_comb begin
    wr_fire  = bus.wr_en && !bus.stall && (mode_reg_q == MODE_INSERT) &&
               (32'(bus.wr_addr) < NLATCH);
    ext_fire = bus.wr_en && !bus.stall && (mode_reg_q == MODE_EXTRACT);
  end

  always_comb begin
    rd_data = '0;
    if (32'(bus.rd_addr) < NLATCH) begin
      rd_data = latch_q[bus.rd_addr];
    end
  end

  always_comb begin
    latch_d     = latch_q;
    merge_in_d  = merge_in_q;
    field_reg_d = field_reg_q;
    mask_reg_d  = mask_reg_q;
    len_reg_d   = len_reg_q;
    mode_reg_d  = mode_reg_q;
    field_out_d = field_out_q;
    out_valid_d = out_valid_q;

    if (!bus.stall) begin
      field_reg_d = bus.field_in & len_mask;
      mask_reg_d  = ~len_mask;
      len_reg_d   = bus.len;
      mode_reg_d  = bus.mode;
      // Forward a same-edge write so the next merge sees the fresh latch.
      merge_in_d  = (wr_fire && (bus.wr_addr == bus.rd_addr)) ? insert_res : rd_data;
      out_valid_d = ext_fire;
      if (ext_fire) begin
        field_out_d = (merge_in_q >> bus.pos) & ext_mask;
      end
      for (int i = 0; i < NLATCH; i++) begin
        if (wr_fire && (32'(bus.wr_addr) == i)) begin
          latch_d[i] = insert_res;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q     <= '{default: '0};
      merge_in_q  <= '0;
      field_reg_q <= '0;
      mask_reg_q  <= '0;
      len_reg_q   <= '0;
      mode_reg_q  <= MODE_INSERT;
      field_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      latch_q     <= latch_d;
      merge_in_q  <= merge_in_d;
      field_reg_q <= field_reg_d;
      mask_reg_q  <= mask_reg_d;
      len_reg_q   <= len_reg_d;
      mode_reg_q  <= mode_reg_d;
      field_out_q <= field_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  logic [NLATCH*W-1:0] data_out_w;

  for (genvar g = 0; g < NLATCH; g++) begin : g_pack
    assign data_out_w[(NLATCH-1-g)*W +: W] = latch_q[g];
  end

  assign bus.data_out  = data_out_w;
  assign bus.field_out = field_out_q;
  assign bus.out_valid = out_valid_q;

endmodule
